// File: rtl/bf_loop_ctrl.sv
// Loop-sequencing controller for the bf-machine: resolves '[' / ']' using a
// hardware return-address stack, scanning program memory only for forward skips.
module bf_loop_ctrl #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 16,
    parameter int SD_W  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_open,
    input  logic [PC_W-1:0] pc,
    input  logic            data_zero,
    output logic            scan_req,
    output logic [PC_W-1:0] scan_addr,
    input  logic            scan_valid,
    input  logic [2:0]      scan_cmd,
    output logic            busy,
    output logic            done,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_target,
    output logic            stack_err,
    output logic [SD_W-1:0] depth
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] CMD_OPEN  = 3'd6;
    localparam logic [2:0] CMD_CLOSE = 3'd7;
    localparam logic [PC_W-1:0] ADDR_MAX = {PC_W{1'b1}};

    typedef enum logic [1:0] {IDLE, EVAL, SCAN, FIN} state_t;

    state_t          state_reg, state_next;
    logic            is_open_reg, is_open_next;
    logic            dz_reg, dz_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] nest_reg, nest_next;
    logic [PC_W-1:0] scan_addr_reg, scan_addr_next;
    logic            pc_load_reg, pc_load_next;
    logic [PC_W-1:0] pc_target_reg, pc_target_next;
    logic            err_reg, err_next;
    logic [SD_W-1:0] depth_reg, depth_next;
    logic            push_en;

    logic [PC_W-1:0] stack_mem [DEPTH];
    logic [PC_W-1:0] top_reg;
    logic [SD_W-1:0] depth_m1;
    logic [AW-1:0]   top_idx;
    logic [AW-1:0]   push_idx;

    assign depth_m1 = depth_reg - SD_W'(1);
    assign top_idx  = depth_m1[AW-1:0];
    assign push_idx = depth_reg[AW-1:0];

    // Top-of-stack is read every cycle; depth is stable from IDLE through EVAL,
    // so top_reg already holds the correct entry when EVAL consumes it.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[push_idx] <= pc_reg;
        end
        top_reg <= stack_mem[top_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            is_open_reg   <= 1'b0;
            dz_reg        <= 1'b0;
            pc_reg        <= '0;
            nest_reg      <= '0;
            scan_addr_reg <= '0;
            pc_load_reg   <= 1'b0;
            pc_target_reg <= '0;
            err_reg       <= 1'b0;
            depth_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            is_open_reg   <= is_open_next;
            dz_reg        <= dz_next;
            pc_reg        <= pc_next;
            nest_reg      <= nest_next;
            scan_addr_reg <= scan_addr_next;
            pc_load_reg   <= pc_load_next;
            pc_target_reg <= pc_target_next;
            err_reg       <= err_next;
            depth_reg     <= depth_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        is_open_next   = is_open_reg;
        dz_next        = dz_reg;
        pc_next        = pc_reg;
        nest_next      = nest_reg;
        scan_addr_next = scan_addr_reg;
        pc_load_next   = pc_load_reg;
        pc_target_next = pc_target_reg;
        err_next       = err_reg;
        depth_next     = depth_reg;
        push_en        = 1'b0;

        case (state_reg)
            IDLE: begin
                pc_load_next = 1'b0;
                if (start) begin
                    is_open_next = is_open;
                    pc_next      = pc;
                    dz_next      = data_zero;
                    state_next   = EVAL;
                end
            end
            EVAL: begin
                pc_load_next = 1'b0;
                state_next   = FIN;
                if (is_open_reg) begin
                    if (dz_reg) begin
                        nest_next      = PC_W'(1);
                        scan_addr_next = pc_reg + PC_W'(1);
                        state_next     = SCAN;
                    end else if (depth_reg == SD_W'(DEPTH)) begin
                        err_next = 1'b1;
                    end else begin
                        push_en    = 1'b1;
                        depth_next = depth_reg + SD_W'(1);
                    end
                end else if (depth_reg == '0) begin
                    err_next = 1'b1;
                end else if (!dz_reg) begin
                    pc_target_next = top_reg;
                    pc_load_next   = 1'b1;
                end else begin
                    depth_next = depth_m1;
                end
            end
            SCAN: begin
                if (scan_valid) begin
                    if (scan_cmd == CMD_CLOSE && nest_reg == PC_W'(1)) begin
                        pc_target_next = scan_addr_reg;
                        pc_load_next   = 1'b1;
                        state_next     = FIN;
                    end else begin
                        if (scan_cmd == CMD_CLOSE) begin
                            nest_next = nest_reg - PC_W'(1);
                        end else if (scan_cmd == CMD_OPEN) begin
                            nest_next = nest_reg + PC_W'(1);
                        end
                        // Running off the end of program memory is an error, never a wrap.
                        if (scan_addr_reg == ADDR_MAX) begin
                            err_next     = 1'b1;
                            pc_load_next = 1'b0;
                            state_next   = FIN;
                        end else begin
                            scan_addr_next = scan_addr_reg + PC_W'(1);
                        end
                    end
                end
            end
            FIN: begin
                pc_load_next = 1'b0;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == FIN);
    assign scan_req  = (state_reg == SCAN);
    assign scan_addr = scan_addr_reg;
    assign pc_load   = pc_load_reg;
    assign pc_target = pc_target_reg;
    assign stack_err = err_reg;
    assign depth     = depth_reg;

endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Self-checking bench for bf_loop_ctrl: transaction-level model with per-cycle
// comparison, directed bracket/scan/error scenarios and literal spot checks.
module tb_bf_loop_ctrl;

    localparam int PC_W  = 8;
    localparam int DEPTH = 16;
    localparam int SD_W  = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            is_open = 1'b0;
    logic [PC_W-1:0] pc = '0;
    logic            data_zero = 1'b0;
    logic            scan_req;
    logic [PC_W-1:0] scan_addr;
    logic            scan_valid = 1'b0;
    logic [2:0]      scan_cmd = 3'd0;
    logic            busy, done, pc_load, stack_err;
    logic [PC_W-1:0] pc_target;
    logic [SD_W-1:0] depth;

    bf_loop_ctrl #(.PC_W(PC_W), .DEPTH(DEPTH), .SD_W(SD_W)) dut (
        .clk(clk), .reset(reset), .start(start), .is_open(is_open), .pc(pc),
        .data_zero(data_zero), .scan_req(scan_req), .scan_addr(scan_addr),
        .scan_valid(scan_valid), .scan_cmd(scan_cmd), .busy(busy), .done(done),
        .pc_load(pc_load), .pc_target(pc_target), .stack_err(stack_err), .depth(depth)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Program memory and latency-configurable responder
    logic [2:0] prog [256];
    int mem_lat = 0;
    int wait_cnt = 0;
    int vcount = 0;
    int last_vaddr = -1;
    bit wrapped = 0;

    always @(negedge clk) begin
        scan_valid = 1'b0;
        if (scan_req && !reset) begin
            if (scan_addr == 0) wrapped = 1;
            if (wait_cnt >= mem_lat) begin
                scan_valid = 1'b1;
                scan_cmd   = prog[scan_addr];
                wait_cnt   = 0;
                vcount++;
                last_vaddr = scan_addr;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Behavioural model: stack as a queue, forward match found by a direct search.
    localparam int P_IDLE = 0, P_EVAL = 1, P_SCAN = 2, P_FIN = 3;
    int phase = P_IDLE;
    int stk[$];
    bit m_err = 0, m_load = 0;
    int m_target = 0, m_addr = 0, m_end = 0, m_match = -1;
    bit c_open, c_dz;
    int c_pc;
    bit check_en = 0;

    function automatic int find_match(input int from);
        int nest = 1;
        for (int a = from; a < 256; a++) begin
            if (prog[a] == 3'd6) nest++;
            else if (prog[a] == 3'd7) begin
                nest--;
                if (nest == 0) return a;
            end
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            phase = P_IDLE; stk.delete(); m_err = 0; m_load = 0; check_en = 1;
        end else begin
            case (phase)
                P_IDLE: if (start) begin
                    c_open = is_open; c_pc = pc; c_dz = data_zero; phase = P_EVAL;
                end
                P_EVAL: begin
                    m_load = 0; phase = P_FIN;
                    if (c_open && c_dz) begin
                        m_addr  = c_pc + 1;
                        m_match = find_match(m_addr);
                        m_end   = (m_match >= 0) ? m_match : 255;
                        phase   = P_SCAN;
                    end else if (c_open) begin
                        if (stk.size() == DEPTH) m_err = 1;
                        else stk.push_back(c_pc);
                    end else if (stk.size() == 0) begin
                        m_err = 1;
                    end else if (!c_dz) begin
                        m_load = 1; m_target = stk[$];
                    end else begin
                        void'(stk.pop_back());
                    end
                end
                P_SCAN: if (scan_valid) begin
                    if (m_addr == m_end) begin
                        phase = P_FIN;
                        if (m_match >= 0) begin m_load = 1; m_target = m_match; end
                        else m_err = 1;
                    end else begin
                        m_addr++;
                    end
                end
                default: begin phase = P_IDLE; m_load = 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", busy, phase != P_IDLE);
            chk("done", done, phase == P_FIN);
            chk("scan_req", scan_req, phase == P_SCAN);
            chk("depth", depth, stk.size());
            chk("stack_err", stack_err, m_err);
            chk("pc_load", pc_load, (phase == P_FIN) ? m_load : 0);
            if (phase == P_FIN && m_load) chk("pc_target", pc_target, m_target);
            if (phase == P_SCAN) chk("scan_addr", scan_addr, m_addr);
        end
    end

    task automatic cmd(input bit op, input int p, input bit dz, input bit poke, output int lat);
        bit got = 0;
        @(negedge clk);
        start = 1'b1; is_open = op; pc = PC_W'(p); data_zero = dz;
        lat = 0;
        for (int k = 1; k <= 3000 && !got; k++) begin
            @(negedge clk);
            start = poke && (k == 2);
            if (poke && k == 2) begin is_open = 1'b0; pc = 8'hAA; data_zero = 1'b0; end
            if (done) begin got = 1; lat = k; end
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    int lat;

    initial begin
        for (int a = 0; a < 256; a++) prog[a] = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_depth", depth, 0);
        chk("rst_err", stack_err, 0);
        chk("rst_scan_addr", scan_addr, 0);
        chk("rst_target", pc_target, 0);

        // Basic push / backward jump / pop
        cmd(1, 5, 0, 0, lat);
        chk("open_lat", lat, 2); chk("open_load", pc_load, 0); chk("open_depth", depth, 1);
        cmd(0, 9, 0, 0, lat);
        chk("close_lat", lat, 2); chk("close_load", pc_load, 1);
        chk("close_target", pc_target, 5); chk("close_depth", depth, 1);
        cmd(0, 9, 1, 0, lat);
        chk("pop_load", pc_load, 0); chk("pop_depth", depth, 0);

        // Forward skip with nesting, latency 3, start poked while busy
        prog[3] = 3'd6; prog[4] = 3'd1; prog[5] = 3'd7; prog[6] = 3'd7;
        mem_lat = 3; vcount = 0;
        cmd(1, 2, 1, 1, lat);
        chk("scan_load", pc_load, 1); chk("scan_target", pc_target, 6);
        chk("scan_valids", vcount, 4); chk("scan_last_addr", last_vaddr, 6);
        chk("scan_depth", depth, 0);

        // Overflow then underflow
        mem_lat = 0;
        for (int i = 0; i < DEPTH; i++) cmd(1, 20 + i, 0, 0, lat);
        chk("full_depth", depth, 16); chk("full_err", stack_err, 0);
        cmd(1, 99, 0, 0, lat);
        chk("ovf_err", stack_err, 1); chk("ovf_depth", depth, 16); chk("ovf_load", pc_load, 0);
        cmd(0, 120, 0, 0, lat);
        chk("after_err_target", pc_target, 35); chk("after_err_load", pc_load, 1);
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        cmd(0, 40, 0, 0, lat);
        chk("udf_err", stack_err, 1); chk("udf_load", pc_load, 0); chk("udf_depth", depth, 0);

        // Scan runoff at top of memory
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        prog[252] = 3'd6; wrapped = 0; mem_lat = 1;
        cmd(1, 250, 1, 0, lat);
        chk("runoff_err", stack_err, 1); chk("runoff_load", pc_load, 0);
        chk("runoff_last", last_vaddr, 255); chk("runoff_wrap", wrapped, 0);

        // Reset in the middle of a scan
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        mem_lat = 2;
        @(negedge clk); start = 1'b1; is_open = 1'b1; pc = 8'd100; data_zero = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_scan_req", scan_req, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 0); chk("abort_req", scan_req, 0); chk("abort_done", done, 0);
        repeat (4) @(negedge clk);
        chk("abort_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
